// File: rtl/fdt_alloc_dispatch_pkg.sv
// Shared definitions for the first-level directory table (FDT) allocator.
// Size-class encodings and table geometry used by the dispatch block.
package fdt_alloc_dispatch_pkg;

    localparam int FDT_BIT_WIDTH   = 4;
    localparam int FDT_INDEX_WIDTH = 6;
    localparam int REQ_ID_WIDTH    = 8;

    typedef enum logic [1:0] {
        REQ_512 = 2'd0,
        REQ_1K  = 2'd1,
        REQ_2K  = 2'd2,
        REQ_4K  = 2'd3
    } req_size_e;

endpackage

// File: rtl/fdt_alloc_dispatch_first_free.sv
// Lowest-zero priority encoder over one FDT column vector.
// Purely combinational: found=0 when every row is full.
module fdt_first_free #(
    parameter int ROWS  = 64,
    parameter int IDX_W = 6
) (
    input  logic [ROWS-1:0]  vec,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    // Scan downward so the lowest free row is the last one written.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = ROWS - 1; i >= 0; i--) begin
            if (!vec[i]) begin
                found = 1'b1;
                idx   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/fdt_alloc_dispatch.sv
// FDT row-full table plus a serialising request dispatcher that picks
// the lowest free row per size class and issues it to the and-tree.
module fdt_alloc_dispatch
    import fdt_alloc_dispatch_pkg::*;
#(
    parameter int ROWS  = 64,
    parameter int IDX_W = FDT_INDEX_WIDTH,
    parameter int ID_W  = REQ_ID_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [ID_W-1:0]          req_id,
    input  logic [1:0]               req_size,
    output logic                     alloc_valid_out,
    output logic [ID_W-1:0]          alloc_id_out,
    output logic [IDX_W-1:0]         alloc_pos_out,
    output logic [1:0]               alloc_size_out,
    output logic                     fail_valid,
    output logic [ID_W-1:0]          fail_id,
    input  logic                     fdt_update_valid,
    input  logic [IDX_W-1:0]         fdt_update_idx,
    input  logic [FDT_BIT_WIDTH-1:0] fdt_update_bit_sequence,
    input  logic                     alloc_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEARCH,
        S_ISSUE,
        S_FAIL,
        S_WAIT
    } state_e;

    state_e state_q, state_d;

    logic [FDT_BIT_WIDTH-1:0][ROWS-1:0] full_q, full_d;

    logic [ID_W-1:0]  id_q, id_d;
    logic [1:0]       size_q, size_d;
    logic             req_ready_q, req_ready_d;
    logic             alloc_valid_q, alloc_valid_d;
    logic [ID_W-1:0]  alloc_id_q, alloc_id_d;
    logic [IDX_W-1:0] alloc_pos_q, alloc_pos_d;
    logic [1:0]       alloc_size_q, alloc_size_d;
    logic             fail_valid_q, fail_valid_d;
    logic [ID_W-1:0]  fail_id_q, fail_id_d;

    logic [ROWS-1:0]  search_vec;
    logic             ff_found;
    logic [IDX_W-1:0] ff_idx;

    always_comb begin
        full_d = full_q;
        if (fdt_update_valid) begin
            for (int k = 0; k < FDT_BIT_WIDTH; k++) begin
                full_d[k][fdt_update_idx] = fdt_update_bit_sequence[k];
            end
        end
    end

    // A write landing in the search cycle must win over the stale row.
    always_comb begin
        search_vec = full_q[size_q];
        if (fdt_update_valid) begin
            search_vec[fdt_update_idx] = fdt_update_bit_sequence[size_q];
        end
    end

    fdt_first_free #(
        .ROWS  (ROWS),
        .IDX_W (IDX_W)
    ) u_first_free (
        .vec   (search_vec),
        .found (ff_found),
        .idx   (ff_idx)
    );

    always_comb begin
        state_d       = state_q;
        id_d          = id_q;
        size_d        = size_q;
        alloc_valid_d = 1'b0;
        alloc_id_d    = alloc_id_q;
        alloc_pos_d   = alloc_pos_q;
        alloc_size_d  = alloc_size_q;
        fail_valid_d  = 1'b0;
        fail_id_d     = fail_id_q;

        unique case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready_q) begin
                    id_d    = req_id;
                    size_d  = req_size;
                    state_d = S_SEARCH;
                end
            end
            S_SEARCH: begin
                if (ff_found) begin
                    alloc_valid_d = 1'b1;
                    alloc_id_d    = id_q;
                    alloc_pos_d   = ff_idx;
                    alloc_size_d  = size_q;
                    state_d       = S_ISSUE;
                end else begin
                    fail_valid_d = 1'b1;
                    fail_id_d    = id_q;
                    state_d      = S_FAIL;
                end
            end
            S_ISSUE: state_d = S_WAIT;
            S_FAIL:  state_d = S_IDLE;
            S_WAIT: begin
                if (alloc_done) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        req_ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            full_q        <= '0;
            id_q          <= '0;
            size_q        <= '0;
            req_ready_q   <= 1'b0;
            alloc_valid_q <= 1'b0;
            alloc_id_q    <= '0;
            alloc_pos_q   <= '0;
            alloc_size_q  <= '0;
            fail_valid_q  <= 1'b0;
            fail_id_q     <= '0;
        end else begin
            state_q       <= state_d;
            full_q        <= full_d;
            id_q          <= id_d;
            size_q        <= size_d;
            req_ready_q   <= req_ready_d;
            alloc_valid_q <= alloc_valid_d;
            alloc_id_q    <= alloc_id_d;
            alloc_pos_q   <= alloc_pos_d;
            alloc_size_q  <= alloc_size_d;
            fail_valid_q  <= fail_valid_d;
            fail_id_q     <= fail_id_d;
        end
    end

    assign req_ready       = req_ready_q;
    assign alloc_valid_out = alloc_valid_q;
    assign alloc_id_out    = alloc_id_q;
    assign alloc_pos_out   = alloc_pos_q;
    assign alloc_size_out  = alloc_size_q;
    assign fail_valid      = fail_valid_q;
    assign fail_id         = fail_id_q;

endmodule

// File: doc/fdt_alloc_dispatch.md
# fdt_alloc_dispatch

First-level directory table (FDT) for the allocator. It holds one "row full" bit per and-tree row per size class. It accepts allocation requests and, for each one, finds the lowest-index row that still has a free slot for the requested size. It then either issues a search request to the and-tree stage or reports allocation failure. The and-tree writes into the table through its FDT update port; this block is the initiator and consumer at the other end of that interface.

## Interface
- `ROWS`, default 64: number of and-tree rows, which is also the number of FDT columns.
- `IDX_W`, default 6: `clog2(ROWS)`, the row index width.
- `ID_W`, default 8: request ID width.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  1  allocation request present.
- `req_ready`  out  1  block can accept a request.
- `req_id`  in  `ID_W`  request tag.
- `req_size`  in  2  size class: 0 = 512, 1 = 1K, 2 = 2K, 3 = 4K.
- `alloc_valid_out`  out  1  one-cycle search request to the and-tree.
- `alloc_id_out`  out  `ID_W`  tag of the issued request.
- `alloc_pos_out`  out  `IDX_W`  selected row.
- `alloc_size_out`  out  2  size class of the issued request.
- `fail_valid`  out  1  one-cycle pulse: no row is free for the requested size.
- `fail_id`  out  `ID_W`  tag of the failed request.
- `fdt_update_valid`  in  1  table write from the and-tree.
- `fdt_update_idx`  in  `IDX_W`  row to write.
- `fdt_update_bit_sequence`  in  4  bit k = row full for size class k.
- `alloc_done`  in  1  pulse from downstream: the issued allocation has been committed and its FDT update has already been presented.

## Operation
- Table: four `ROWS`-bit vectors, `full[k]`. Reset clears them to all 0 (everything free).
- Table write: whenever `fdt_update_valid` is high, `full[k][fdt_update_idx] <= fdt_update_bit_sequence[k]` for k = 0..3. Writes are accepted in every state and never stall.
- FSM states: IDLE, SEARCH, ISSUE, FAIL, WAIT.
- IDLE:
  - `req_ready` = 1.
  - On `req_valid`: capture `req_id` and `req_size`, then go to SEARCH.
- SEARCH:
  - Search vector V = `full[size]`, with a same-cycle update to `fdt_update_idx` bypassed into V.
  - Pick the lowest index i with V[i] = 0.
  - If i is found: register it as `pos` and go to ISSUE. Otherwise go to FAIL.
- ISSUE:
  - `alloc_valid_out` = 1 with the captured id, size and pos. Exactly one cycle.
  - Go to WAIT.
- FAIL:
  - `fail_valid` = 1 and `fail_id` = captured id. Exactly one cycle.
  - Go to IDLE.
- WAIT:
  - On `alloc_done`, go to IDLE.
  - `alloc_done` is ignored in every other state.
- Only one allocation is outstanding at a time. This serialisation prevents two requests from selecting the same last free slot before the and-tree update lands.

## Timing
- All outputs are registered.
- Reset values: `req_ready` 0, `alloc_valid_out` 0, `alloc_id_out` 0, `alloc_pos_out` 0, `alloc_size_out` 0, `fail_valid` 0, `fail_id` 0. State is IDLE.
- `req_ready` rises on the first clock edge after `rst_n` deasserts.
- Request handshake completes on an edge where `req_valid` and `req_ready` are both high (call it T). `req_ready` is low from T+1.
- `alloc_valid_out` or `fail_valid` is high in cycle T+2.
- Fail path: `req_ready` is high again at T+3.
- Success path: `req_ready` is high the cycle after `alloc_done` is sampled in WAIT. Minimum turnaround is 4 cycles.
- Non-bypassed table updates are visible to a SEARCH in the cycle after the write.
- `alloc_*` fields hold their values after the pulse; they are only valid while `alloc_valid_out` is high.
- If `rst_n` is asserted mid-operation, the block aborts immediately: the table is cleared, the FSM returns to IDLE and the outputs return to their reset values. The outstanding `alloc_done` is not expected.

## Structure
- Shared package/header holds:
  - size-class encodings `REQ_512`, `REQ_1K`, `REQ_2K`, `REQ_4K` = 0..3;
  - `FDT_BIT_WIDTH` = 4;
  - `FDT_INDEX_WIDTH` = `IDX_W`;
  - `REQ_ID_WIDTH`.
- FSM state encoding stays local to this block.
- One sub-module, `fdt_first_free`: a purely combinational `ROWS`-bit lowest-zero priority encoder with outputs `found` and `idx`.

## Test plan
- Reset, empty table; request size 0, id 5 accepted at T: `alloc_valid_out` at T+2 with pos 0, size 0, id 5; `fail_valid` never asserts.
- Update idx 0 with 4'b0001, then a size-0 request: pos 1. After `alloc_done`, a size-1 request: pos 0.
- Update all 64 rows with 4'b1000, then a size-3 request, id 9: `fail_valid` at T+2 with `fail_id` 9; no `alloc_valid_out`; `req_ready` high at T+3.
- Update idx 0 with 4'b0001 in the same cycle as SEARCH for size 0: bypass selects pos 1. `full[0][0]` reads 1 afterwards.
- Hold `req_valid` high through WAIT: `req_ready` stays 0 with no second issue. After an `alloc_done` pulse, the next request is accepted one cycle later.
- Assert `rst_n` low during WAIT after marking rows full: all outputs 0 and the table cleared. After release, a size-0 request returns pos 0.
